// File: rtl/pulse_stretcher_if.sv
// Strobe-in / stretched-level-out signal bundle for pulse_stretcher.
// Parameters must match the MAX_WIDTH / PEND_MAX of the attached pulse_stretcher.
interface pulse_stretcher_if #(
   parameter int MAX_WIDTH = 255,
   parameter int PEND_MAX  = 15
);
   localparam int WW = $clog2(MAX_WIDTH + 1);
   localparam int PW = $clog2(PEND_MAX + 1);

   // There is no valid/ready pair here: every cycle with pulse_in high is one
   // request that the stretcher always absorbs (launched, queued or dropped
   // with overflow). There is no back-pressure, and width_in matters only on
   // the cycle a pulse launches.
   logic          pulse_in;
   logic [WW-1:0] width_in;
   logic          output_signal;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   modport master (
      output pulse_in, width_in,
      input  output_signal, busy, pending, overflow
   );

   modport slave (
      input  pulse_in, width_in,
      output output_signal, busy, pending, overflow
   );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into held pulses of programmable width with a forced low gap;
// strobes arriving mid-pulse are queued in order. Define PULSE_STRETCHER_RETRIGGER_EN for retrigger mode.
module pulse_stretcher #(
   parameter int MAX_WIDTH = 255,
   parameter int GAP       = 1,
   parameter int PEND_MAX  = 15
) (
   input  logic             clk,
   input  logic             rst,
   pulse_stretcher_if.slave bus,
   output logic [1:0]       state_o
);
   localparam int WW = $clog2(MAX_WIDTH + 1);
   localparam int PW = $clog2(PEND_MAX + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [WW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [PW-1:0] pend_q, pend_d;
   logic          ovf_q, ovf_d;

   logic [WW-1:0] width_clamped;
   logic          launch_window;
   logic          launch;

   always_comb begin
      width_clamped = bus.width_in;
      if (bus.width_in > WW'(MAX_WIDTH)) width_clamped = WW'(MAX_WIDTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      gap_d         = gap_q;
      pend_d        = pend_q;
      ovf_d         = 1'b0;
      launch_window = 1'b0;
      launch        = 1'b0;

      case (state_q)
         S_HIGH: begin
            cnt_d = cnt_q - WW'(1);
            if (cnt_q == WW'(1)) begin
               if (GAP > 0) begin
                  state_d = S_GAP;
                  gap_d   = GW'(GAP);
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - GW'(1);
            if (gap_q == GW'(1)) state_d = S_IDLE;
         end
         default: ;
      endcase

`ifdef PULSE_STRETCHER_RETRIGGER_EN
      // Any strobe during the gap cuts it short; a zero-width strobe never truncates a running pulse.
      launch_window = (state_q == S_IDLE) || (state_q == S_GAP);
      launch        = launch_window && bus.pulse_in;
      if ((state_q == S_HIGH) && bus.pulse_in && (width_clamped != '0)) begin
         state_d = S_HIGH;
         cnt_d   = width_clamped;
      end
      pend_d = '0;
`else
      launch_window = (state_q == S_IDLE) ||
                      ((state_q == S_GAP) && (gap_q == GW'(1))) ||
                      ((state_q == S_HIGH) && (cnt_q == WW'(1)) && (GAP == 0));
      launch        = launch_window && (bus.pulse_in || (pend_q != '0));

      // Queued requests launch first; a strobe on that same cycle takes the freed slot.
      if (launch && (pend_q != '0)) begin
         if (!bus.pulse_in) pend_d = pend_q - PW'(1);
      end else if (bus.pulse_in && !launch) begin
         if (pend_q == PW'(PEND_MAX)) ovf_d = 1'b1;
         else                         pend_d = pend_q + PW'(1);
      end
`endif

      if (launch) begin
         gap_d = '0;
         if (width_clamped != '0) begin
            state_d = S_HIGH;
            cnt_d   = width_clamped;
         end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      end
   end

   always_comb begin
      bus.output_signal = (state_q == S_HIGH);
      bus.busy          = (state_q != S_IDLE);
      bus.pending       = pend_q;
      bus.overflow      = ovf_q;
      state_o           = state_q;
   end
endmodule

// File: tb/tb_pulse_stretcher.sv
// Drives three pulse_stretcher instances (GAP = 0, 1, 2) with the same strobe stream and
// compares every output each cycle against a request-scheduling reference model.
module tb_pulse_stretcher;
   localparam int MAXW   = 20;
   localparam int PMAX   = 15;
   localparam int DEPTH  = 1200;
   localparam int EW     = 7;

   logic clk;
   logic rst;

   pulse_stretcher_if #(.MAX_WIDTH(MAXW), .PEND_MAX(PMAX)) ifs0 ();
   pulse_stretcher_if #(.MAX_WIDTH(MAXW), .PEND_MAX(PMAX)) ifs1 ();
   pulse_stretcher_if #(.MAX_WIDTH(MAXW), .PEND_MAX(PMAX)) ifs2 ();
   logic [1:0] st0, st1, st2;

   pulse_stretcher #(.MAX_WIDTH(MAXW), .GAP(0), .PEND_MAX(PMAX)) dut0 (
      .clk(clk), .rst(rst), .bus(ifs0), .state_o(st0));
   pulse_stretcher #(.MAX_WIDTH(MAXW), .GAP(1), .PEND_MAX(PMAX)) dut1 (
      .clk(clk), .rst(rst), .bus(ifs1), .state_o(st1));
   pulse_stretcher #(.MAX_WIDTH(MAXW), .GAP(2), .PEND_MAX(PMAX)) dut2 (
      .clk(clk), .rst(rst), .bus(ifs2), .state_o(st2));

   logic [3*EW-1:0] obs_v;
   assign obs_v = {ifs2.output_signal, ifs2.busy, ifs2.overflow, ifs2.pending,
                   ifs1.output_signal, ifs1.busy, ifs1.overflow, ifs1.pending,
                   ifs0.output_signal, ifs0.busy, ifs0.overflow, ifs0.pending};

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stimulus program and expected timelines
   logic       pulse_a [DEPTH];
   logic [4:0] width_a [DEPTH];
   logic       rst_a   [DEPTH];
   bit         e_out   [3][DEPTH];
   bit         e_busy  [3][DEPTH];
   bit         e_ovf   [3][DEPTH];
   int         e_pend  [3][DEPTH];
   int         pos;

   logic [3*EW-1:0] exp_q[$];
   int n_tests;
   int n_fail;

   task automatic put(input bit p, input int w, input bit r);
      pulse_a[pos] = p;
      width_a[pos] = w[4:0];
      rst_a[pos]   = r;
      pos++;
   endtask

   task automatic idle(input int n, input int w);
      for (int i = 0; i < n; i++) put(1'b0, w, 1'b0);
   endtask

   // Scheduling view: each request launches at the first cycle >= its turn, and a
   // launch of width W at cycle L frees the next launch slot at L+W+GAP (or L+1 if W==0).
   task automatic run_model(input int k, input int g);
      int pend;
      int next_free;
      int w;
      pend = 0;
      next_free = 0;
      for (int c = 0; c < pos; c++) begin
         if (rst_a[c]) begin
            pend = 0;
            next_free = c + 1;
            for (int j = c + 1; j < DEPTH; j++) begin
               e_out[k][j]  = 1'b0;
               e_busy[k][j] = 1'b0;
            end
            e_ovf[k][c+1]  = 1'b0;
            e_pend[k][c+1] = 0;
         end else begin
            e_ovf[k][c+1] = 1'b0;
            if (c >= next_free && (pend > 0 || pulse_a[c])) begin
               w = (int'(width_a[c]) > MAXW) ? MAXW : int'(width_a[c]);
               if (pend > 0 && !pulse_a[c]) pend--;
               if (w == 0) begin
                  next_free = c + 1;
               end else begin
                  for (int j = c + 1; j <= c + w; j++) e_out[k][j] = 1'b1;
                  for (int j = c + 1; j <= c + w + g; j++) e_busy[k][j] = 1'b1;
                  next_free = c + w + g;
               end
            end else if (pulse_a[c]) begin
               if (pend == PMAX) e_ovf[k][c+1] = 1'b1;
               else pend++;
            end
            e_pend[k][c+1] = pend;
         end
      end
   endtask

   task automatic chk(input string tag, input int k, input int c,
                      input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s inst_gap%0d cycle %0d: observed %0d expected %0d", tag, k, c, obs, exp);
      end
   endtask

   initial begin
      logic [3*EW-1:0] e;
      int base;
      n_tests = 0;
      n_fail  = 0;
      pos     = 0;
      for (int i = 0; i < DEPTH; i++) begin
         pulse_a[i] = 1'b0;
         width_a[i] = '0;
         rst_a[i]   = 1'b0;
         for (int k = 0; k < 3; k++) begin
            e_out[k][i] = 1'b0; e_busy[k][i] = 1'b0; e_ovf[k][i] = 1'b0; e_pend[k][i] = 0;
         end
      end

      // reset
      for (int i = 0; i < 3; i++) put(1'b0, 0, 1'b1);
      idle(3, 5);
      // single strobe, width 5
      put(1'b1, 5, 1'b0);
      idle(12, 5);
      // three back-to-back strobes, width 3
      for (int i = 0; i < 3; i++) put(1'b1, 3, 1'b0);
      idle(25, 3);
      // 20 strobes during one clamped-width pulse: saturation and overflow
      for (int i = 0; i < 20; i++) put(1'b1, 31, 1'b0);
      idle(90, 2);
      // zero-width strobe from idle
      put(1'b1, 0, 1'b0);
      idle(6, 0);
      // reset mid-pulse with two queued requests
      for (int i = 0; i < 3; i++) put(1'b1, 8, 1'b0);
      put(1'b0, 8, 1'b1);
      idle(30, 8);
      // random traffic with occasional reset
      for (int i = 0; i < 400; i++)
         put($urandom_range(0, 3) == 0, $urandom_range(0, 31), $urandom_range(0, 149) == 0);
      idle(100, 4);

      run_model(0, 0);
      run_model(1, 1);
      run_model(2, 2);
      for (int c = 1; c < pos; c++) begin
         e = '0;
         for (int k = 0; k < 3; k++)
            e[k*EW +: EW] = {e_out[k][c], e_busy[k][c], e_ovf[k][c], 4'(e_pend[k][c])};
         exp_q.push_back(e);
      end

      // driver loop: inputs change just after posedge, outputs checked at negedge
      @(posedge clk);
      #1;
      for (int c = 0; c < pos; c++) begin
         rst = rst_a[c];
         ifs0.pulse_in = pulse_a[c]; ifs0.width_in = width_a[c];
         ifs1.pulse_in = pulse_a[c]; ifs1.width_in = width_a[c];
         ifs2.pulse_in = pulse_a[c]; ifs2.width_in = width_a[c];
         @(negedge clk);
         if (c >= 1) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 3; k++) begin
               base = k * EW;
               chk("output_signal", k, c, {3'b0, obs_v[base+6]}, {3'b0, e[base+6]});
               chk("busy",          k, c, {3'b0, obs_v[base+5]}, {3'b0, e[base+5]});
               chk("overflow",      k, c, {3'b0, obs_v[base+4]}, {3'b0, e[base+4]});
               chk("pending",       k, c, obs_v[base +: 4], e[base +: 4]);
            end
         end
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
